// File: rtl/ysyx_22041412_ifu_if.sv
// Fetch-unit bus bundle: execute redirect, instruction memory port and decode output.
// Decode handshake: an entry moves when inst_valid && inst_ready at a posedge; while
// inst_valid is high and inst_ready is low, inst/inst_pc/inst_fault do not change.
interface ysyx_22041412_ifu_if;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_en;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, inst_ready,
        output imem_en, imem_addr, inst_valid, inst, inst_pc, inst_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, inst_ready,
        input  imem_en, imem_addr, inst_valid, inst, inst_pc, inst_fault
    );
endinterface

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: PC owner, 1-cycle synchronous imem driver and a one-entry
// output buffer toward decode, with redirect handling and misaligned-target faults.
module ysyx_22041412_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22041412_ifu_if.master        bus,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [63:0] pc;
    logic        misaligned;
    logic        xfer;

    assign misaligned = |bus.redirect_pc[1:0];
    assign xfer       = bus.inst_valid && bus.inst_ready;
    assign dbg_state  = state;

    always_comb begin
        state_n       = state;
        bus.imem_en   = 1'b0;
        bus.imem_addr = '0;
        case (state)
            ST_ISSUE: begin
                // Only issue when the buffer will be free by the time the data returns.
                if (!bus.inst_valid || bus.inst_ready) begin
                    bus.imem_en   = 1'b1;
                    bus.imem_addr = pc >> 2;
                    state_n       = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_n = ST_ISSUE;
            ST_FAULT:   state_n = ST_FAULT;
            default:    state_n = ST_ISSUE;
        endcase
        if (bus.redirect_valid) begin
            bus.imem_en   = 1'b0;
            bus.imem_addr = '0;
            state_n       = misaligned ? ST_FAULT : ST_ISSUE;
        end
        if (rst) begin
            bus.imem_en   = 1'b0;
            bus.imem_addr = '0;
            state_n       = ST_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_ISSUE;
            pc             <= RESET_PC;
            bus.inst_valid <= 1'b0;
            bus.inst       <= '0;
            bus.inst_pc    <= '0;
            bus.inst_fault <= 1'b0;
        end else begin
            state <= state_n;
            if (bus.redirect_valid) begin
                // A redirect wins over a pending capture; the in-flight word is dropped.
                pc <= bus.redirect_pc;
                if (misaligned) begin
                    bus.inst_valid <= 1'b1;
                    bus.inst       <= NOP_INST;
                    bus.inst_pc    <= bus.redirect_pc;
                    bus.inst_fault <= 1'b1;
                end else begin
                    bus.inst_valid <= 1'b0;
                end
            end else if (state == ST_CAPTURE) begin
                bus.inst_valid <= 1'b1;
                bus.inst       <= bus.imem_rdata;
                bus.inst_pc    <= pc;
                bus.inst_fault <= 1'b0;
                pc             <= pc + 64'd4;
            end else if (xfer) begin
                bus.inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Bench for ysyx_22041412_ifu: directed scenarios, then random ready/redirect traffic
// checked against an in-order instruction-stream model of what decode should receive.
module tb_ysyx_22041412_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dbg_state;
    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_fails  = 0;

    ysyx_22041412_ifu_if bus ();

    ysyx_22041412_ifu dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data for an issue appears in the following cycle, 0 otherwise.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_en ? mem[bus.imem_addr[7:0]] : 32'h0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_pc;
        logic [63:0] rpc;
        logic        allowed;
        int          mode;
        int          ntx;

        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[0]    = 32'h0010_0093;
        mem[1]    = 32'h0020_0113;
        mem[2]    = 32'h0030_0193;
        mem[3]    = 32'h0040_0213;
        mem[8'h40] = 32'h1234_5678;
        mem[8'hFF] = 32'hCAFE_F00D;

        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;

        // Reset state
        nxt();
        smp();
        check("rst_en", bus.imem_en, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_valid", bus.inst_valid, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_pc", bus.inst_pc, 0);
        check("rst_fault", bus.inst_fault, 0);

        // First fetch and streaming
        nxt(); rst = 1'b0;
        smp();
        check("c1_en", bus.imem_en, 1);
        check("c1_addr", bus.imem_addr, 64'h2000_0000);
        check("c1_valid", bus.inst_valid, 0);
        nxt(); smp();
        check("c2_en", bus.imem_en, 0);
        check("c2_valid", bus.inst_valid, 0);
        nxt(); smp();
        check("c3_valid", bus.inst_valid, 1);
        check("c3_inst", bus.inst, 32'h0010_0093);
        check("c3_pc", bus.inst_pc, RST_PC);
        for (int k = 1; k < 4; k++) begin
            check("str_en", bus.imem_en, 1);
            check("str_addr", bus.imem_addr, (RST_PC + 64'(4 * k)) >> 2);
            nxt(); smp();
            check("str_gap_valid", bus.inst_valid, 0);
            nxt(); smp();
            check("str_valid", bus.inst_valid, 1);
            check("str_pc", bus.inst_pc, RST_PC + 64'(4 * k));
            check("str_inst", bus.inst, {32'h0, mem[k]});
        end

        // Back-pressure: buffer held, no fetch, then resume
        bus.inst_ready = 1'b0;
        do_reset();
        smp(); check("stl_c1_en", bus.imem_en, 1);
        nxt(); nxt(); smp();
        check("stl_valid", bus.inst_valid, 1);
        check("stl_en0", bus.imem_en, 0);
        for (int i = 0; i < 5; i++) begin
            nxt(); smp();
            check("stl_hold_valid", bus.inst_valid, 1);
            check("stl_hold_inst", bus.inst, {32'h0, mem[0]});
            check("stl_hold_pc", bus.inst_pc, RST_PC);
            check("stl_hold_en", bus.imem_en, 0);
        end
        nxt(); bus.inst_ready = 1'b1; smp();
        check("stl_resume_en", bus.imem_en, 1);
        check("stl_resume_addr", bus.imem_addr, 64'h2000_0001);
        nxt(); smp(); check("stl_gap", bus.inst_valid, 0);
        nxt(); smp();
        check("stl_next_valid", bus.inst_valid, 1);
        check("stl_next_pc", bus.inst_pc, RST_PC + 64'd4);
        check("stl_next_inst", bus.inst, {32'h0, mem[1]});

        // Redirect during a pending capture
        do_reset();
        nxt();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0100;
        smp(); check("rdc_en", bus.imem_en, 0);
        nxt(); bus.redirect_valid = 1'b0; smp();
        check("rdc_dropped", bus.inst_valid, 0);
        check("rdc_en1", bus.imem_en, 1);
        check("rdc_addr", bus.imem_addr, 64'h2000_0040);
        nxt(); nxt(); smp();
        check("rdc_valid", bus.inst_valid, 1);
        check("rdc_pc", bus.inst_pc, 64'h8000_0100);
        check("rdc_inst", bus.inst, 64'h1234_5678);

        // Misaligned redirect enters the fault state
        nxt();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0102;
        smp(); check("mis_en", bus.imem_en, 0);
        nxt(); bus.redirect_valid = 1'b0; smp();
        check("mis_valid", bus.inst_valid, 1);
        check("mis_fault", bus.inst_fault, 1);
        check("mis_inst", bus.inst, {32'h0, NOP});
        check("mis_pc", bus.inst_pc, 64'h8000_0102);
        check("mis_en0", bus.imem_en, 0);
        for (int i = 0; i < 4; i++) begin
            nxt(); smp();
            check("mis_idle_valid", bus.inst_valid, 0);
            check("mis_idle_en", bus.imem_en, 0);
        end
        nxt();
        bus.redirect_valid = 1'b1; bus.redirect_pc = RST_PC;
        smp(); check("mis_rd_en", bus.imem_en, 0);
        nxt(); bus.redirect_valid = 1'b0; smp();
        check("mis_resume_en", bus.imem_en, 1);
        check("mis_resume_addr", bus.imem_addr, 64'h2000_0000);
        nxt(); nxt(); smp();
        check("mis_resume_pc", bus.inst_pc, RST_PC);
        check("mis_resume_fault", bus.inst_fault, 0);
        check("mis_resume_inst", bus.inst, {32'h0, mem[0]});

        // PC wrap at the top of the address space, then reset mid-capture
        do_reset();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        smp(); check("wrp_issue_redirect_en", bus.imem_en, 0);
        nxt(); bus.redirect_valid = 1'b0; smp();
        check("wrp_addr", bus.imem_addr, 64'h3FFF_FFFF_FFFF_FFFF);
        nxt(); nxt(); smp();
        check("wrp_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrp_inst", bus.inst, 64'hCAFE_F00D);
        check("wrp_next_addr", bus.imem_addr, 0);
        nxt(); nxt(); smp();
        check("wrp_zero_pc", bus.inst_pc, 0);
        check("wrp_zero_inst", bus.inst, {32'h0, mem[0]});
        nxt(); rst = 1'b1; smp();
        check("rmc_en", bus.imem_en, 0);
        check("rmc_addr", bus.imem_addr, 0);
        nxt(); rst = 1'b0; smp();
        check("rmc_valid", bus.inst_valid, 0);
        check("rmc_inst", bus.inst, 0);
        check("rmc_pc", bus.inst_pc, 0);
        check("rmc_fault", bus.inst_fault, 0);
        check("rmc_en", bus.imem_en, 1);
        check("rmc_addr", bus.imem_addr, 64'h2000_0000);
        nxt(); nxt(); smp();
        check("rmc_restart_pc", bus.inst_pc, RST_PC);

        // Random traffic against the delivered-stream model
        do_reset();
        exp_pc = RST_PC;
        mode   = 0;
        ntx    = 0;
        for (int c = 0; c < 2000; c++) begin
            bus.inst_ready = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            rpc = {$urandom(), $urandom()};
            rpc[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.redirect_pc = rpc;
            smp();
            if (bus.inst_valid) begin
                check("rnd_pc", bus.inst_pc, exp_pc);
                if (mode == 1) begin
                    check("rnd_fault", bus.inst_fault, 1);
                    check("rnd_nop", bus.inst, {32'h0, NOP});
                end else begin
                    check("rnd_fault", bus.inst_fault, 0);
                    check("rnd_inst", bus.inst, {32'h0, mem[exp_pc[9:2]]});
                end
            end
            if (mode == 1) check("rnd_fault_present", bus.inst_valid, 1);
            if (mode == 2) check("rnd_dead_valid", bus.inst_valid, 0);
            allowed = (mode == 0) && !bus.redirect_valid && (!bus.inst_valid || bus.inst_ready);
            if (!allowed) check("rnd_en_block", bus.imem_en, 0);
            if (bus.imem_en)
                check("rnd_addr", bus.imem_addr, (bus.inst_valid ? exp_pc + 64'd4 : exp_pc) >> 2);
            if (bus.inst_valid && bus.inst_ready) begin
                ntx++;
                if (mode == 1) mode = 2;
                else exp_pc = exp_pc + 64'd4;
            end
            if (bus.redirect_valid) begin
                exp_pc = bus.redirect_pc;
                mode   = (bus.redirect_pc[1:0] != 2'b00) ? 1 : 0;
            end
            nxt();
        end
        bus.redirect_valid = 1'b0;
        check("rnd_progress", 64'(ntx >= 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
